mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between two requesters: port A (data access) and port B (instruction fetch).
- Runs round-robin arbitration and sequences one memory transaction at a time.
- Drives the select line of the existing 32-bit 2:1 address/data mux in front of memory: sel=1 passes port A, sel=0 passes port B.
- Sits between the CPU fetch/memory stages and the memory model. Includes a transaction timeout.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between a data port (A)
// and an instruction-fetch port (B). One transaction at a time, with a cycle
// timeout that aborts a transaction the memory never acknowledges.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          done_a,
  output logic          err_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          done_b,
  output logic          err_b,
  output logic [DW-1:0] rdata_b,
  output logic          sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;       // 1 = A was granted last, 0 = B
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          done_a_q, done_a_d, err_a_q, err_a_d;
  logic          done_b_q, done_b_d, err_b_q, err_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic          win_a;

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_a_q    <= 1'b0;
      err_a_q     <= 1'b0;
      rdata_a_q   <= '0;
      done_b_q    <= 1'b0;
      err_b_q     <= 1'b0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_a_q    <= done_a_d;
      err_a_q     <= err_a_d;
      rdata_a_q   <= rdata_a_d;
      done_b_q    <= done_b_d;
      err_b_q     <= err_b_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  // Next-state: grant in IDLE, then wait for ack or timeout in BUSY.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_a_d    = 1'b0;
    err_a_d     = 1'b0;
    rdata_a_d   = rdata_a_q;
    done_b_d    = 1'b0;
    err_b_d     = 1'b0;
    rdata_b_d   = rdata_b_q;
    // On a tie, A wins unless A was the last port served.
    win_a       = req_a && (!req_b || !last_q);

    case (state_q)
      IDLE: begin
        mem_en_d = 1'b0;
        if (req_a || req_b) begin
          sel_d       = win_a;
          last_d      = win_a;
          mem_addr_d  = win_a ? addr_a  : addr_b;
          mem_we_d    = win_a ? we_a    : we_b;
          mem_wdata_d = win_a ? wdata_a : wdata_b;
          mem_en_d    = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // An ack on the timeout cycle still completes normally.
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          if (sel_q) begin
            done_a_d = 1'b1;
            err_a_d  = !mem_ack;
            if (!mem_ack)      rdata_a_d = '0;
            else if (!mem_we_q) rdata_a_d = mem_rdata;
          end else begin
            done_b_d = 1'b1;
            err_b_d  = !mem_ack;
            if (!mem_ack)      rdata_b_d = '0;
            else if (!mem_we_q) rdata_b_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel       = sel_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done_a    = done_a_q;
  assign err_a     = err_a_q;
  assign rdata_a   = rdata_a_q;
  assign done_b    = done_b_q;
  assign err_b     = err_b_q;
  assign rdata_b   = rdata_b_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever done_a/done_b pulses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [31:0] addr_a = 0, wdata_a = 0, addr_b = 0, wdata_b = 0;
  logic        done_a, err_a, done_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        sel, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        mem_ack = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port_a;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .done_a(done_a), .err_a(err_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .done_b(done_b), .err_b(err_b), .rdata_b(rdata_b),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pa, input logic e, input logic [31:0] d);
    exp_t x;
    x.port_a = pa;
    x.err    = e;
    x.rdata  = d;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One-cycle memory acknowledge with read data.
  task automatic ack(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done_a || done_b) begin
      exp_t e;
      n_checks++;
      if (done_a && done_b) begin
        n_fail++;
        $display("FAIL both_done: got done_a=1 done_b=1 expected one");
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done_a=%0b done_b=%0b expected none", done_a, done_b);
      end else begin
        e = sb.pop_front();
        if (done_a !== e.port_a ||
            (done_a ? err_a : err_b) !== e.err ||
            (done_a ? rdata_a : rdata_b) !== e.rdata) begin
          n_fail++;
          $display("FAIL completion: got port_a=%0b err=%0b rdata=0x%08h expected port_a=%0b err=%0b rdata=0x%08h",
                   done_a, done_a ? err_a : err_b, done_a ? rdata_a : rdata_b,
                   e.port_a, e.err, e.rdata);
        end else begin
          $display("ok   completion port_a=%0b err=%0b rdata=0x%08h", e.port_a, e.err, e.rdata);
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_sel", sel, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata_a", rdata_a, 0);

    // 1: single read from A
    push(1, 0, 32'hDEADBEEF);
    req_a = 1; we_a = 0; addr_a = 32'h100;
    tick();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_sel", sel, 1);
    chk("t1_mem_we", mem_we, 0);
    tick(); tick();
    ack(32'hDEADBEEF);
    req_a = 0;
    chk("t1_done_a", done_a, 1);
    chk("t1_mem_en_drop", mem_en, 0);
    tick();
    chk("t1_done_pulse", done_a, 0);
    chk("t1_rdata_hold", rdata_a, 32'hDEADBEEF);

    // ack while idle must be ignored
    ack(32'h0BAD0BAD);
    chk("idle_ack_mem_en", mem_en, 0);
    chk("idle_ack_rdata_a", rdata_a, 32'hDEADBEEF);

    // 2: tie after reset alternates A,B,A,B
    do_reset();
    req_a = 1; addr_a = 32'h10; req_b = 1; we_b = 0; addr_b = 32'h20;
    push(1, 0, 32'h1); push(0, 0, 32'h2); push(1, 0, 32'h3); push(0, 0, 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t2_sel_%0d", k), sel, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t2_addr_%0d", k), mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
      ack(32'(k + 1));
      chk($sformatf("t2_gap_%0d", k), mem_en, 0);
      if (k == 3) begin
        req_a = 0; req_b = 0;
      end
    end
    tick();
    chk("t2_idle_after", mem_en, 0);

    // 3: B write, rdata_b must keep its previous read value
    push(0, 0, 32'h4);
    req_b = 1; we_b = 1; addr_b = 32'h200; wdata_b = 32'h12345678;
    tick();
    chk("t3_sel", sel, 0);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_wdata", mem_wdata, 32'h12345678);
    wdata_b = 32'hFFFF0000; addr_b = 32'h999; req_a = 1;
    tick();
    chk("t3_wdata_held", mem_wdata, 32'h12345678);
    chk("t3_addr_held", mem_addr, 32'h200);
    chk("t3_we_held", mem_we, 1);
    req_a = 0;
    ack(32'hAAAA5555);
    req_b = 0; we_b = 0;
    chk("t3_done_b", done_b, 1);
    chk("t3_we_clear", mem_we, 0);
    tick();

    // 4: A read, never acknowledged
    push(1, 1, 32'h0);
    req_a = 1; we_a = 0; addr_a = 32'h300;
    tick();
    chk("t4_sel", sel, 1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (done_a !== 1'b0 || mem_en !== 1'b1)
        chk($sformatf("t4_busy_%0d", k), {done_a, mem_en}, 2'b01);
    end
    chk("t4_busy_end_mem_en", mem_en, 1);
    tick();
    req_a = 0;
    chk("t4_timeout_done", done_a, 1);
    chk("t4_timeout_err", err_a, 1);
    chk("t4_mem_en", mem_en, 0);
    tick();

    // 5: ack on the timeout cycle wins
    push(1, 0, 32'hCAFEF00D);
    req_a = 1; addr_a = 32'h304;
    tick();
    for (int k = 1; k <= 15; k++) tick();
    ack(32'hCAFEF00D);
    req_a = 0;
    chk("t5_done", done_a, 1);
    chk("t5_err", err_a, 0);
    tick();

    // 6: reset mid-transaction, then a tie grants A
    req_b = 1; addr_b = 32'h400;
    tick();
    chk("t6_sel_b", sel, 0);
    req_b = 0;
    tick();
    rst = 1;
    tick();
    chk("t6_rst_mem_en", mem_en, 0);
    chk("t6_rst_sel", sel, 0);
    rst = 0;
    push(1, 0, 32'h55);
    req_a = 1; addr_a = 32'h500; req_b = 1; addr_b = 32'h600;
    tick();
    chk("t6_tie_sel", sel, 1);
    chk("t6_tie_addr", mem_addr, 32'h500);
    ack(32'h55);
    req_a = 0; req_b = 0;
    tick();
    tick();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
